// File: rtl/npu_definitions.sv
// Shared NPU definitions: perf counter bank indices and sweep engine state encoding.
package npu_definitions;

   localparam int unsigned CNT_CYCLE         = 0;
   localparam int unsigned CNT_INSTR         = 1;
   localparam int unsigned CNT_MAC           = 2;
   localparam int unsigned CNT_MEM           = 3;
   localparam int unsigned CNT_STALL         = 4;
   localparam int unsigned NUM_PERF_COUNTERS = 5;
   localparam int unsigned PERF_SEL_W        = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } sweep_state_e;

endpackage

// File: rtl/perf_sample_fifo.sv
// Synchronous first-word-fall-through FIFO; push while full is accepted when a pop frees a slot.
module perf_sample_fifo #(
   parameter int unsigned WIDTH = 45,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign pop_ok   = pop && !empty;
   assign push_ok  = push && (!full || pop_ok);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care while empty, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/perf_counter_reader.sv
// Sweeps the perf counter bank via select/value and streams tagged samples through a FWFT FIFO.
module perf_counter_reader
   import npu_definitions::*;
#(
   parameter int unsigned NUM_COUNTERS = NUM_PERF_COUNTERS,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned SEL_W        = PERF_SEL_W,
   parameter int unsigned INTERVAL_W   = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  periodic_en,
   input  logic [INTERVAL_W-1:0] interval,
   input  logic                  clear_missed,
   output logic [SEL_W-1:0]      counter_select,
   input  logic [DATA_W-1:0]     counter_value,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [SEL_W-1:0]      out_index,
   output logic                  out_last,
   output logic [7:0]            out_seq,
   output logic                  busy,
   output logic                  missed
);

   localparam int unsigned SEQ_W   = 8;
   localparam int unsigned ENTRY_W = SEQ_W + SEL_W + 1 + DATA_W;
   localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

   sweep_state_e          state;
   logic [SEQ_W-1:0]      seq;
   logic [INTERVAL_W-1:0] tmr_cnt;
   logic                  timer_on_c;
   logic                  timer_fire_c;
   logic                  req_c;
   logic                  last_c;
   logic                  push_c;
   logic                  pop_c;
   logic [ENTRY_W-1:0]    push_entry;
   logic [ENTRY_W-1:0]    head_entry;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [CNT_W-1:0]      fifo_count;

   assign timer_on_c   = periodic_en && (interval != '0);
   assign timer_fire_c = timer_on_c && (tmr_cnt == INTERVAL_W'(1));
   assign req_c        = start || timer_fire_c;
   assign last_c       = (counter_select == SEL_W'(NUM_COUNTERS - 1));
   assign push_c       = (state == ST_SWEEP) && !fifo_full;
   assign push_entry   = {seq, counter_select, last_c, counter_value};
   assign pop_c        = out_valid && out_ready;
   assign out_valid    = !fifo_empty;
   assign {out_seq, out_index, out_last, out_data} = head_entry;

   // Interval timer: reloads while disabled, fires one request when it reaches 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr_cnt <= '0;
      end else if (!timer_on_c || (tmr_cnt <= INTERVAL_W'(1))) begin
         tmr_cnt <= interval;
      end else begin
         tmr_cnt <= tmr_cnt - INTERVAL_W'(1);
      end
   end

   // Sweep FSM: steps the select, stalls on a full FIFO, flags dropped requests.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         counter_select <= '0;
         seq            <= '0;
         busy           <= 1'b0;
         missed         <= 1'b0;
      end else begin
         if (req_c && (state == ST_SWEEP)) missed <= 1'b1;
         else if (clear_missed)            missed <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (req_c) begin
                  state          <= ST_SWEEP;
                  counter_select <= '0;
                  busy           <= 1'b1;
               end
            end
            ST_SWEEP: begin
               if (!fifo_full) begin
                  if (last_c) begin
                     state          <= ST_IDLE;
                     counter_select <= '0;
                     seq            <= seq + SEQ_W'(1);
                     busy           <= 1'b0;
                  end else begin
                     counter_select <= counter_select + SEL_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   perf_sample_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_c),
      .push_data (push_entry),
      .pop       (pop_c),
      .pop_data  (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Full flag must always agree with the occupancy count.
   fifo_full_consistent: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH)));

endmodule
